day_phase_scheduler: RTL and testbench
======================================

DAY_PHASE_SCHEDULER -- requirements
Module: day_phase_scheduler

Interface
REQ-001 SHALL have parameter MIN_GREEN, default 4, minimum green length in cycles (>=1).
REQ-002 SHALL have parameter MAX_GREEN, default 20, green length cap in cycles (>=MIN_GREEN, <=255).
REQ-003 SHALL have parameter CLEAR_TIME, default 2, all-stop clearance length in cycles (>=1).
REQ-004 SHALL have parameter SHIFT, default 4, right-shift applied to lane demand before adding to MIN_GREEN.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 enable  input  1  high while day-time mode is selected.
REQ-008 n1, n2, e1, e2, s1, s2, w1, w2  input  8 each  queued-vehicle count per lane, unsigned.
REQ-009 lightOut  output  8  go (1) / stop (0) per lane: [1:0]=S1,S2; [3:2]=E1,E2; [5:4]=N1,N2; [7:6]=W1,W2.
REQ-010 state  output  3  current phase: IDLE=0, NS_CLEAR=1, NS_GO=2, EW_CLEAR=3, EW_GO=4.
REQ-011 remaining  output  8  cycles left in the current timed phase, 0 in IDLE.

Function
REQ-012 SHALL define NS demand D_NS = max(n1,n2,s1,s2) and EW demand D_EW = max(e1,e2,w1,w2), 8-bit unsigned.
REQ-013 SHALL compute green length G = MIN_GREEN + (D >> SHIFT) in 9 bits, saturated to MAX_GREEN.
REQ-014 lightOut SHALL be a Moore decode of state: NS_GO -> 8'h33, EW_GO -> 8'hCC, all other states -> 8'h00.
REQ-015 IDLE: remaining=0; on a clock edge with enable=1 SHALL go to NS_CLEAR with remaining loaded to CLEAR_TIME.
REQ-016 Every timed phase SHALL last exactly its loaded value in cycles; remaining decrements by 1 each edge, and the phase exits on the edge where remaining==1.
REQ-017 NS_CLEAR exit SHALL go to NS_GO, loading remaining with G computed from D_NS sampled on that edge.
REQ-018 NS_GO exit: if D_EW==0 and D_NS!=0, SHALL stay in NS_GO and reload remaining with a freshly computed G(D_NS); otherwise SHALL go to EW_CLEAR loading CLEAR_TIME.
REQ-019 EW_CLEAR exit SHALL go to EW_GO, loading G(D_EW) sampled on that edge.
REQ-020 EW_GO exit: if D_NS==0 and D_EW!=0, SHALL stay in EW_GO and reload G(D_EW); otherwise SHALL go to NS_CLEAR loading CLEAR_TIME.
REQ-021 Both demands zero at a GO exit SHALL alternate normally, each green lasting MIN_GREEN.
REQ-022 Lane counts changing mid-phase SHALL NOT alter the current remaining; they are sampled only on load edges.
REQ-023 enable=0 on any clock edge SHALL force state=IDLE and remaining=0 on that edge, overriding every other transition.
REQ-024 NS_GO and EW_GO SHALL never be adjacent; every group change SHALL pass through a CLEAR state, so lightOut never switches between 8'h33 and 8'hCC without at least CLEAR_TIME cycles of 8'h00.
REQ-025 Saturation SHALL hold at D=8'hFF with any legal SHIFT (no wrap of G).

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, set state=IDLE, remaining=0, lightOut=8'h00.
REQ-027 Deassertion of rst SHALL take effect on the following clock edge; the first transition requires enable=1 at that edge.
REQ-028 Reset asserted mid-phase SHALL discard all timing; restart always begins at NS_CLEAR.

Verification (defaults unless stated)
REQ-029 rst pulse during EW_GO -> same-cycle state=0, lightOut=8'h00, remaining=0.
REQ-030 enable=1, all counts 0 -> NS_CLEAR 2 cycles (00), NS_GO 4 cycles (33), EW_CLEAR 2 cycles (00), EW_GO 4 cycles (CC), repeating with period 12.
REQ-031 n1=8'h80, others 0 -> NS_GO loads 12; at exit D_EW=0, so NS_GO reloads 12 repeatedly; lightOut holds 8'h33 with no CLEAR.
REQ-032 s2=8'hFF, w1=8'h10 -> NS_GO length 19, EW_CLEAR 2, EW_GO length 5; with MAX_GREEN=10 override, NS_GO length 10.
REQ-033 enable dropped for one edge during NS_GO (remaining=3) -> state=IDLE, lightOut 8'h00 next cycle; re-enable -> NS_CLEAR 2 cycles, then a full fresh green.
REQ-034 w2 changed 0->8'hF0 mid-EW_GO -> current remaining unaffected; the new value is used only at the next EW load.

Source files
------------

// File: rtl/day_phase_scheduler.sv
// rtl/day_phase_scheduler.sv - day-time four-way signal phase scheduler with demand-scaled greens
module day_phase_scheduler #(
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 20,
  parameter int CLEAR_TIME = 2,
  parameter int SHIFT      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] n1,
  input  logic [7:0] n2,
  input  logic [7:0] e1,
  input  logic [7:0] e2,
  input  logic [7:0] s1,
  input  logic [7:0] s2,
  input  logic [7:0] w1,
  input  logic [7:0] w2,
  output logic [7:0] lightOut,
  output logic [2:0] state,
  output logic [7:0] remaining
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] NS_CLEAR = 3'd1;
  localparam logic [2:0] NS_GO    = 3'd2;
  localparam logic [2:0] EW_CLEAR = 3'd3;
  localparam logic [2:0] EW_GO    = 3'd4;

  localparam logic [7:0] CLEAR_LEN = 8'(CLEAR_TIME);
  localparam logic [8:0] MAX_G9    = 9'(MAX_GREEN);
  localparam logic [8:0] MIN_G9    = 9'(MIN_GREEN);

  logic [7:0] d_ns;
  logic [7:0] d_ew;
  logic [7:0] g_ns;
  logic [7:0] g_ew;
  logic [2:0] state_nxt;
  logic [7:0] remaining_nxt;
  logic       phase_end;

  function automatic logic [7:0] max4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    logic [7:0] ab;
    logic [7:0] cd;
    ab = (a > b) ? a : b;
    cd = (c > d) ? c : d;
    return (ab > cd) ? ab : cd;
  endfunction

  // The sum is kept in 9 bits so a large demand cannot wrap below the cap.
  function automatic logic [7:0] green_len(input logic [7:0] dem);
    logic [8:0] sum;
    sum = MIN_G9 + {1'b0, (dem >> SHIFT)};
    if (sum > MAX_G9) begin
      return MAX_G9[7:0];
    end
    return sum[7:0];
  endfunction

  // Per-direction demand and the green length it would earn right now.
  always_comb begin
    d_ns = max4(n1, n2, s1, s2);
    d_ew = max4(e1, e2, w1, w2);
    g_ns = green_len(d_ns);
    g_ew = green_len(d_ew);
  end

  // Next phase; lane counts only matter on the edge that loads a new length.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    // A zero count in a timed phase is unreachable but is treated as expiry.
    phase_end     = (remaining <= 8'd1);
    if (!enable) begin
      state_nxt     = IDLE;
      remaining_nxt = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt     = NS_CLEAR;
          remaining_nxt = CLEAR_LEN;
        end
        NS_CLEAR: begin
          if (phase_end) begin
            state_nxt     = NS_GO;
            remaining_nxt = g_ns;
          end else begin
            remaining_nxt = remaining - 8'd1;
          end
        end
        NS_GO: begin
          if (phase_end) begin
            if ((d_ew == 8'd0) && (d_ns != 8'd0)) begin
              remaining_nxt = g_ns;
            end else begin
              state_nxt     = EW_CLEAR;
              remaining_nxt = CLEAR_LEN;
            end
          end else begin
            remaining_nxt = remaining - 8'd1;
          end
        end
        EW_CLEAR: begin
          if (phase_end) begin
            state_nxt     = EW_GO;
            remaining_nxt = g_ew;
          end else begin
            remaining_nxt = remaining - 8'd1;
          end
        end
        EW_GO: begin
          if (phase_end) begin
            if ((d_ns == 8'd0) && (d_ew != 8'd0)) begin
              remaining_nxt = g_ew;
            end else begin
              state_nxt     = NS_CLEAR;
              remaining_nxt = CLEAR_LEN;
            end
          end else begin
            remaining_nxt = remaining - 8'd1;
          end
        end
        default: begin
          state_nxt     = IDLE;
          remaining_nxt = 8'd0;
        end
      endcase
    end
  end

  // Phase register; reset drops everything without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= 8'd0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  // Lamp outputs follow the registered phase only.
  always_comb begin
    case (state)
      NS_GO:   lightOut = 8'h33;
      EW_GO:   lightOut = 8'hCC;
      default: lightOut = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_day_phase_scheduler.sv
// tb/tb_day_phase_scheduler.sv - randomized and directed check of day_phase_scheduler against a phase model
module tb_day_phase_scheduler;

  localparam int MIN_G = 4;
  localparam int CLR   = 2;
  localparam int SH    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] n1 = 0, n2 = 0, e1 = 0, e2 = 0, s1 = 0, s2 = 0, w1 = 0, w2 = 0;

  logic [7:0] light_a, light_b;
  logic [2:0] state_a, state_b;
  logic [7:0] rem_a, rem_b;

  int checks = 0;
  int errors = 0;

  // Model: phase id, length of the current phase, cycles already spent in it.
  int m_ph [2];
  int m_len[2];
  int m_el [2];
  int m_max[2];

  always #5 clk = ~clk;

  day_phase_scheduler u_dut_a (
    .clk(clk), .rst(rst), .enable(enable),
    .n1(n1), .n2(n2), .e1(e1), .e2(e2), .s1(s1), .s2(s2), .w1(w1), .w2(w2),
    .lightOut(light_a), .state(state_a), .remaining(rem_a)
  );

  day_phase_scheduler #(.MAX_GREEN(10)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable),
    .n1(n1), .n2(n2), .e1(e1), .e2(e2), .s1(s1), .s2(s2), .w1(w1), .w2(w2),
    .lightOut(light_b), .state(state_b), .remaining(rem_b)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int green(input int d, input int mx);
    int g;
    g = MIN_G + (d / (1 << SH));
    return (g > mx) ? mx : g;
  endfunction

  function automatic int dem_ns();
    int v[4];
    int m;
    v[0] = n1; v[1] = n2; v[2] = s1; v[3] = s2;
    m = 0;
    foreach (v[i]) if (v[i] > m) m = v[i];
    return m;
  endfunction

  function automatic int dem_ew();
    int v[4];
    int m;
    v[0] = e1; v[1] = e2; v[2] = w1; v[3] = w2;
    m = 0;
    foreach (v[i]) if (v[i] > m) m = v[i];
    return m;
  endfunction

  task automatic model_idle();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_len[k] = 0; m_el[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int dn, de;
    dn = dem_ns();
    de = dem_ew();
    for (int k = 0; k < 2; k++) begin
      if (rst || !enable) begin
        m_ph[k] = 0; m_len[k] = 0; m_el[k] = 0;
      end else if (m_ph[k] == 0) begin
        m_ph[k] = 1; m_len[k] = CLR; m_el[k] = 0;
      end else begin
        m_el[k]++;
        if (m_el[k] >= m_len[k]) begin
          m_el[k] = 0;
          case (m_ph[k])
            1: begin m_ph[k] = 2; m_len[k] = green(dn, m_max[k]); end
            2: if (de == 0 && dn != 0) m_len[k] = green(dn, m_max[k]);
               else begin m_ph[k] = 3; m_len[k] = CLR; end
            3: begin m_ph[k] = 4; m_len[k] = green(de, m_max[k]); end
            default: if (dn == 0 && de != 0) m_len[k] = green(de, m_max[k]);
                     else begin m_ph[k] = 1; m_len[k] = CLR; end
          endcase
        end
      end
    end
  endtask

  function automatic int exp_light(input int k);
    return (m_ph[k] == 2) ? 'h33 : (m_ph[k] == 4) ? 'hCC : 0;
  endfunction

  function automatic int exp_rem(input int k);
    return (m_ph[k] == 0) ? 0 : m_len[k] - m_el[k];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_state_a"}, 9'(state_a), 9'(m_ph[0]));
    chk({tag, "_rem_a"},   9'(rem_a),   9'(exp_rem(0)));
    chk({tag, "_light_a"}, 9'(light_a), 9'(exp_light(0)));
    chk({tag, "_state_b"}, 9'(state_b), 9'(m_ph[1]));
    chk({tag, "_rem_b"},   9'(rem_b),   9'(exp_rem(1)));
    chk({tag, "_light_b"}, 9'(light_b), 9'(exp_light(1)));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Reset between edges must clear outputs immediately.
  task automatic rst_pulse(input string tag);
    rst = 1'b1;
    model_idle();
    #1;
    check_all(tag);
    rst = 1'b0;
  endtask

  task automatic clear_lanes();
    n1 = 0; n2 = 0; e1 = 0; e2 = 0; s1 = 0; s2 = 0; w1 = 0; w2 = 0;
  endtask

  initial begin
    int waited;
    int r;
    m_max[0] = 20;
    m_max[1] = 10;
    model_idle();

    // Async reset before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_all("reset");
    run("reset_hold", 2);
    rst = 1'b0;

    // Disabled: stays idle.
    run("disabled", 3);

    // All zero demand: fixed 12-cycle alternation.
    enable = 1'b1;
    run("zero_dem", 30);

    // NS-only demand: NS_GO reloads 12 repeatedly.
    n1 = 8'h80;
    run("ns_only", 45);

    // Mixed demand, saturation in the capped instance.
    clear_lanes();
    s2 = 8'hFF; w1 = 8'h10;
    run("mixed", 60);

    // Drop enable for one edge while NS_GO shows remaining 3.
    clear_lanes();
    waited = 0;
    while (!(m_ph[0] == 2 && exp_rem(0) == 3) && waited < 100) begin
      cycle("seek_ns3");
      waited++;
    end
    if (waited >= 100) begin
      errors++;
      $error("FAIL seek_ns3 observed=timeout expected=NS_GO remaining 3");
    end
    enable = 1'b0;
    cycle("en_drop");
    enable = 1'b1;
    run("re_enable", 14);

    // w2 changes mid EW_GO; only the next EW load may see it.
    waited = 0;
    while (!(m_ph[0] == 4 && m_el[0] == 1) && waited < 100) begin
      cycle("seek_ewgo");
      waited++;
    end
    if (waited >= 100) begin
      errors++;
      $error("FAIL seek_ewgo observed=timeout expected=EW_GO");
    end
    w2 = 8'hF0;
    run("w2_mid", 40);

    // Reset pulse during EW_GO.
    waited = 0;
    while (m_ph[0] != 4 && waited < 100) begin
      cycle("seek_ewgo2");
      waited++;
    end
    if (waited >= 100) begin
      errors++;
      $error("FAIL seek_ewgo2 observed=timeout expected=EW_GO");
    end
    rst_pulse("rst_ewgo");
    run("after_rst", 10);

    // Randomized traffic with occasional disables and resets.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        case ($urandom_range(0, 7))
          0: n1 = 8'($urandom_range(0, 255));
          1: n2 = 8'($urandom_range(0, 255));
          2: e1 = 8'($urandom_range(0, 255));
          3: e2 = 8'($urandom_range(0, 255));
          4: s1 = 8'($urandom_range(0, 255));
          5: s2 = 8'($urandom_range(0, 255));
          6: w1 = 8'($urandom_range(0, 255));
          default: w2 = 8'($urandom_range(0, 255));
        endcase
      end else if (r < 13) begin
        e1 = 0; e2 = 0; w1 = 0; w2 = 0;
      end else if (r < 16) begin
        n1 = 0; n2 = 0; s1 = 0; s2 = 0;
      end
      enable = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 299) == 0) rst_pulse("rand_rst");
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
